// File: rtl/spwm_pkg.sv
// Shared constants for the sinusoidal-PWM gate generator: default width,
// one-hot dead-time FSM encoding and dead-time bounds.
package spwm_pkg;

  localparam int WIDTH_DEF = 12;
  localparam int DEAD_MIN  = 1;
  localparam int DEAD_MAX  = 255;

  typedef enum logic [2:0] {
    ST_DEAD = 3'b001,
    ST_HI   = 3'b010,
    ST_LO   = 3'b100
  } state_e;

  localparam int ST_HI_BIT = 1;
  localparam int ST_LO_BIT = 2;

  // Keeps an out-of-range DEAD_CYCLES from wrapping the 8-bit dead-time counter.
  function automatic int dead_clamp(input int d);
    return (d < DEAD_MIN) ? DEAD_MIN : ((d > DEAD_MAX) ? DEAD_MAX : d);
  endfunction

endpackage

// File: rtl/spwm_carrier.sv
// Symmetric up/down triangle carrier, 0..CARRIER_MAX..0 with a period of
// 2*CARRIER_MAX clocks; strobes at the valley.
module spwm_carrier
  import spwm_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int CARRIER_MAX = 1638
) (
  input  logic             clk_in,
  input  logic             rst_in,
  output logic [WIDTH-1:0] tri_q,
  output logic             sample_strobe
);

  localparam logic [WIDTH-1:0] TOP_M1 = WIDTH'(CARRIER_MAX - 1);

  logic dir_dn;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tri_q  <= '0;
      dir_dn <= 1'b0;
    end else if (!dir_dn) begin
      tri_q <= tri_q + WIDTH'(1);
      if (tri_q == TOP_M1) dir_dn <= 1'b1;
    end else begin
      tri_q <= tri_q - WIDTH'(1);
      if (tri_q == WIDTH'(1)) dir_dn <= 1'b0;
    end
  end

  assign sample_strobe = (tri_q == '0);

endmodule

// File: rtl/spwm_gate_gen.sv
// Inverter-leg gate generator: valley-sampled sine reference vs. triangle
// carrier, driving complementary gates through a dead-time FSM.
module spwm_gate_gen
  import spwm_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int CARRIER_MAX = 1638,
  parameter int DEAD_CYCLES = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] sine_ref,
  output logic             gate_hi,
  output logic             gate_lo,
  output logic [WIDTH-1:0] carrier,
  output logic             sample_strobe
);

  localparam logic [7:0] DT_LOAD = 8'(dead_clamp(DEAD_CYCLES) - 1);

  logic [WIDTH-1:0] tri_q;
  logic [WIDTH-1:0] ref_q;
  logic             pwm_raw;
  state_e           state;
  logic [7:0]       dt_cnt;

  spwm_carrier #(
    .WIDTH      (WIDTH),
    .CARRIER_MAX(CARRIER_MAX)
  ) u_carrier (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .tri_q        (tri_q),
    .sample_strobe(sample_strobe)
  );

  // Regular sampling: the reference only moves at the carrier valley.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)             ref_q <= '0;
    else if (sample_strobe) ref_q <= sine_ref;
  end

  assign pwm_raw = (ref_q > tri_q);

  // Exit from DEAD looks at pwm_raw only at expiry, so sub-dead-time pulses vanish.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= ST_DEAD;
      dt_cnt <= DT_LOAD;
    end else begin
      case (state)
        ST_HI: if (!pwm_raw) begin
          state  <= ST_DEAD;
          dt_cnt <= DT_LOAD;
        end
        ST_LO: if (pwm_raw) begin
          state  <= ST_DEAD;
          dt_cnt <= DT_LOAD;
        end
        ST_DEAD: begin
          if (dt_cnt != 8'd0) dt_cnt <= dt_cnt - 8'd1;
          else                state  <= pwm_raw ? ST_HI : ST_LO;
        end
        default: begin
          state  <= ST_DEAD;
          dt_cnt <= DT_LOAD;
        end
      endcase
    end
  end

  // Single state-register bits: glitch-free and cleared directly by reset.
  assign gate_hi = state[ST_HI_BIT];
  assign gate_lo = state[ST_LO_BIT];
  assign carrier = tri_q;

endmodule

// File: tb/tb_spwm_gate_gen.sv
// Directed bench for spwm_gate_gen: three configurations run side by side
// against hand-derived cycle tables.
module tb_spwm_gate_gen;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [11:0] sine_a = '0, sine_b = '0, sine_c = '0;
  logic [11:0] car_a, car_b, car_c;
  logic        hi_a, lo_a, stb_a, hi_b, lo_b, stb_b, hi_c, lo_c, stb_c;

  int n_tests = 0;
  int n_fail  = 0;
  int hi_cnt, lo_cnt, dead_cnt, both_cnt, hi_b_cnt;

  always #5 clk_in = ~clk_in;

  // A: CARRIER_MAX 8, dead 2.  B: CARRIER_MAX 1024, dead 8.  C: CARRIER_MAX 8, dead 4.
  spwm_gate_gen #(.WIDTH(12), .CARRIER_MAX(8), .DEAD_CYCLES(2)) u_a (
    .clk_in(clk_in), .rst_in(rst_in), .sine_ref(sine_a), .gate_hi(hi_a),
    .gate_lo(lo_a), .carrier(car_a), .sample_strobe(stb_a));
  spwm_gate_gen #(.WIDTH(12), .CARRIER_MAX(1024), .DEAD_CYCLES(8)) u_b (
    .clk_in(clk_in), .rst_in(rst_in), .sine_ref(sine_b), .gate_hi(hi_b),
    .gate_lo(lo_b), .carrier(car_b), .sample_strobe(stb_b));
  spwm_gate_gen #(.WIDTH(12), .CARRIER_MAX(8), .DEAD_CYCLES(4)) u_c (
    .clk_in(clk_in), .rst_in(rst_in), .sine_ref(sine_c), .gate_hi(hi_c),
    .gate_lo(lo_c), .carrier(car_c), .sample_strobe(stb_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int tri8(input int k);
    int m;
    m = k % 16;
    return (m <= 8) ? m : 16 - m;
  endfunction

  initial begin
    // Reset values
    repeat (3) begin
      @(negedge clk_in); #1;
      check("rst_gates_a", {hi_a, lo_a}, 0);
      check("rst_gates_b", {hi_b, lo_b}, 0);
      check("rst_carrier_a", car_a, 0);
    end

    // Phase 1: carrier shape + duty (A), saturation high (B), narrow pulse (C)
    hi_cnt = 0; lo_cnt = 0; dead_cnt = 0; both_cnt = 0; hi_b_cnt = 0;
    for (int k = 0; k <= 2100; k++) begin
      @(negedge clk_in);
      if (k == 0) rst_in = 1'b0;
      sine_a = 12'd4;
      sine_b = 12'd1208;
      sine_c = (k == 32) ? 12'd2 : 12'd0;
      #1;
      if (k == 0) check("strobe_first_cycle", stb_a, 1);
      if (k <= 40) begin
        check("carrier_a", car_a, tri8(k));
        check("strobe_a", stb_a, tri8(k) == 0);
      end
      if (k < 2) check("initial_dead_a", {hi_a, lo_a}, 0);
      if (k >= 32 && k <= 47) begin
        check("gate_hi_a", hi_a, k <= 36);
        check("gate_lo_a", lo_a, k >= 39 && k <= 45);
        hi_cnt   += hi_a;
        lo_cnt   += lo_a;
        dead_cnt += (!hi_a && !lo_a);
      end
      both_cnt += (hi_a & lo_a) + (hi_b & lo_b) + (hi_c & lo_c);
      if (k < 8) check("initial_dead_b", {hi_b, lo_b}, 0);
      else if (hi_b && !lo_b) hi_b_cnt++;
      case (k)
        1023: check("carrier_b_1023", car_b, 1023);
        1024: check("carrier_b_peak", car_b, 1024);
        1025: check("carrier_b_after_peak", car_b, 1023);
        2047: check("carrier_b_2047", car_b, 1);
        2048: begin
          check("carrier_b_valley", car_b, 0);
          check("strobe_b_period", stb_b, 1);
        end
        default: ;
      endcase
      if (k < 4) check("initial_dead_c", {hi_c, lo_c}, 0);
      if (k >= 30 && k <= 60) begin
        check("narrow_hi_c", hi_c, 0);
        check("narrow_lo_c", lo_c, !((k >= 34 && k <= 37) || (k >= 48 && k <= 51)));
      end
    end
    check("hi_a_cycles", hi_cnt, 5);
    check("lo_a_cycles", lo_cnt, 7);
    check("dead_a_cycles", dead_cnt, 4);
    check("both_gates_high", both_cnt, 0);
    check("hi_b_saturated", hi_b_cnt, 2093);

    // Mid-pulse reset: gate must drop before the next clock edge
    check("hi_b_before_rst", hi_b, 1);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_hi_b", hi_b, 0);
    check("async_rst_lo_b", lo_b, 0);
    check("async_rst_carrier_b", car_b, 0);
    repeat (2) @(negedge clk_in);

    // Phase 2: reference toggling between valleys must be ignored
    hi_cnt = 0; lo_cnt = 0;
    for (int k = 0; k <= 47; k++) begin
      @(negedge clk_in);
      if (k == 0) rst_in = 1'b0;
      sine_a = (k % 16 == 0) ? 12'd6 : ((k % 2 == 0) ? 12'd6 : 12'd2);
      sine_b = 12'd0;
      sine_c = 12'd0;
      #1;
      if (k >= 32) begin
        check("sample_hi_a", hi_a, k <= 38 || k >= 46);
        check("sample_lo_a", lo_a, k >= 41 && k <= 43);
        hi_cnt += hi_a;
        lo_cnt += lo_a;
      end
    end
    check("sample_hi_cycles", hi_cnt, 9);
    check("sample_lo_cycles", lo_cnt, 3);

    // Phase 3: zero reference holds the low side on
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    lo_cnt = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk_in);
      if (k == 0) rst_in = 1'b0;
      sine_a = 12'd0;
      #1;
      if (k < 2) check("zero_ref_dead", {hi_a, lo_a}, 0);
      else begin
        check("zero_ref_hi", hi_a, 0);
        lo_cnt += lo_a;
      end
    end
    check("zero_ref_lo_cycles", lo_cnt, 39);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spwm_gate_gen.md
# spwm_gate_gen

Sinusoidal-PWM gate generator for one inverter leg. It consumes the 12-bit sine reference stream produced by the sine LUT stage. It compares a regularly sampled copy of that reference against an internal symmetric triangular carrier. It drives complementary high-side and low-side gate signals with dead-time insertion.

## Interface
- `WIDTH`, 12: width of the reference and carrier.
- `CARRIER_MAX`, 1638: carrier peak value. Legal range is 1..2^WIDTH-1.
- `DEAD_CYCLES`, 8: dead time in clocks. Legal range is 1..255.
- `clk_in`, in, 1: system clock. All logic is rising-edge.
- `rst_in`, in, 1: reset, asynchronous, active-high.
- `sine_ref`, in, WIDTH: sine reference sample, unsigned. It is a new value every clock, from the LUT stage.
- `gate_hi`, out, 1: high-side gate drive, active-high.
- `gate_lo`, out, 1: low-side gate drive, active-high.
- `carrier`, out, WIDTH: current carrier value, for debug and scope.
- `sample_strobe`, out, 1: high for one cycle when `carrier == 0` (carrier valley).

## Operation
**Carrier**
- Registers `tri` (WIDTH bits) and `dir` (0 = up, 1 = down).
- Reset values: `tri` = 0, `dir` = up.
- Counting up: increment `tri`. When `tri == CARRIER_MAX-1`, the next value is `CARRIER_MAX` and `dir` becomes down.
- Counting down: decrement `tri`. When `tri == 1`, the next value is 0 and `dir` becomes up.
- Each extreme value is held for exactly one cycle. The period is `2*CARRIER_MAX` clocks.
- `carrier` = `tri`.

**Reference sampling**
- Register `ref_q` resets to 0.
- On any rising edge where `tri == 0`, `ref_q <= sine_ref`. At all other edges `ref_q` holds.
- Changes on `sine_ref` between valleys have no effect.

**Comparison**
- `pwm_raw = (ref_q > tri)`, unsigned and combinational from registers.
- If `ref_q == 0`, `pwm_raw` is constantly 0.
- If `ref_q > CARRIER_MAX`, `pwm_raw` is constantly 1.

**Dead-time FSM**
- States are one-hot: DEAD, HI_ON, LO_ON. Counter `dt_cnt` is 8 bits.
- Gate decoding:
  - `gate_hi` = (state == HI_ON).
  - `gate_lo` = (state == LO_ON).
  - Both gates are 0 in DEAD and are never both 1.
- Reset: state = DEAD, `dt_cnt` = `DEAD_CYCLES-1`. Both gates read 0.
- HI_ON: if `pwm_raw == 0`, go to DEAD and load `dt_cnt` = `DEAD_CYCLES-1`.
- LO_ON: if `pwm_raw == 1`, go to DEAD and load `dt_cnt` = `DEAD_CYCLES-1`.
- DEAD with `dt_cnt != 0`: decrement `dt_cnt`.
- DEAD with `dt_cnt == 0`: go to HI_ON if `pwm_raw`, otherwise LO_ON.
- The exit is evaluated on the value of `pwm_raw` at expiry. A raw pulse shorter than the dead time is therefore absorbed, and the leg returns to its previous side after a full dead time.
- DEAD always lasts exactly `DEAD_CYCLES` cycles.

## Timing
- **Turn-off:** if `pwm_raw` changes in cycle t, the active gate is 0 from cycle t+1.
- **Turn-on:** the opposite gate is asserted from cycle t+1+`DEAD_CYCLES`.
- **After reset release:** both gates are 0 for `DEAD_CYCLES` cycles, then one gate asserts.
- **`sample_strobe`:** asserted in the first cycle after reset release, then every `2*CARRIER_MAX` cycles.
- **Reference latency:** a new `ref_q` affects `pwm_raw` from the cycle after the strobe.
- **Reset mid-operation:** both gates drop to 0 asynchronously, with no waiting for dead time.
- **Gate glitching:** gates are decoded from the one-hot state register only. No combinational path runs from `sine_ref` to the gates.

## Structure
- Shared package `spwm_pkg`: `WIDTH` default, the FSM state enum/one-hot constants, and a `DEAD_CYCLES` bounds-check constant.
- Sub-module `spwm_carrier`: the up/down triangle counter. Ports: `clk_in`, `rst_in`, `tri`, `sample_strobe`.
- Top level: reference latch, comparator and dead-time FSM.

## Test plan
1. **Reset values:** assert `rst_in` for 3 cycles, then release. Expect during reset `gate_hi` = `gate_lo` = 0, `carrier` = 0. Expect `sample_strobe` = 1 in the first cycle after release.
2. **Carrier shape:** `CARRIER_MAX` = 8. Expect the sequence 0,1,…,8,7,…,1,0 with a period of 16. Expect `sample_strobe` exactly at each 0.
3. **Duty and dead time:** `CARRIER_MAX` = 8, `DEAD_CYCLES` = 2, `sine_ref` held at 4.
   - Expect `pwm_raw` high for 7 of every 16 cycles.
   - Expect `gate_hi` high for 5 cycles and `gate_lo` high for 7 cycles.
   - Expect two 2-cycle DEAD gaps per period and never both gates high.
4. **Sampling:** `sine_ref` toggles between 2 and 6 every cycle except at the valley, where it is 6. Expect `ref_q` = 6 and the duty of ref 6. The toggling must have no effect.
5. **Extremes:** `sine_ref` = 0 gives `gate_lo` permanently 1 after the first dead time. `sine_ref` = 1208 with `CARRIER_MAX` = 1024 gives `gate_hi` permanently 1.
6. **Mid-pulse reset and narrow pulse:**
   - Assert `rst_in` while `gate_hi` = 1. Expect `gate_hi` to drop in the same cycle, asynchronously.
   - With `DEAD_CYCLES` = 4, force a 2-cycle `pwm_raw` pulse. Expect the gate to return to its previous side after 4 DEAD cycles.
